// File: rtl/swing_pipeline.sv
//============================================================================
// Module      : swing_pipeline
// Description : DEPTH-stage valid/ready pipeline that applies a bitwise
//               AND/OR/XOR/majority to three operands and counts results.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module swing_pipeline #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic [WIDTH-1:0] C_in,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    output logic [WIDTH-1:0] LOGIC_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      txn_count
);

    localparam logic [1:0] c_MODE_AND = 2'b00;
    localparam logic [1:0] c_MODE_OR  = 2'b01;
    localparam logic [1:0] c_MODE_XOR = 2'b10;

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_a   [DEPTH];
    logic [WIDTH-1:0] r_b   [DEPTH];
    logic [WIDTH-1:0] r_res [DEPTH];
    logic [15:0]      r_txn_count;

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_up_valid;
    logic [WIDTH-1:0] w_up_a   [DEPTH];
    logic [WIDTH-1:0] w_up_b   [DEPTH];
    logic [WIDTH-1:0] w_up_res [DEPTH];
    logic [WIDTH-1:0] w_res;

    always_comb begin
        w_res = (A_in & B_in) | (A_in & C_in) | (B_in & C_in);
        case (mode)
            c_MODE_AND: w_res = A_in & B_in & C_in;
            c_MODE_OR:  w_res = A_in | B_in | C_in;
            c_MODE_XOR: w_res = A_in ^ B_in ^ C_in;
            default:    w_res = (A_in & B_in) | (A_in & C_in) | (B_in & C_in);
        endcase
    end

    // A stage may load iff out_ready is high or any stage at or after it is empty.
    always_comb begin
        logic v_any;
        w_load = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_any = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                v_any = v_any | ~r_valid[j];
            end
            w_load[k] = v_any;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_up
        if (k == 0) begin : g_first
            assign w_up_valid[k] = in_valid;
            assign w_up_a[k]     = A_in;
            assign w_up_b[k]     = B_in;
            assign w_up_res[k]   = w_res;
        end else begin : g_next
            assign w_up_valid[k] = r_valid[k-1];
            assign w_up_a[k]     = r_a[k-1];
            assign w_up_b[k]     = r_b[k-1];
            assign w_up_res[k]   = r_res[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_res[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_up_valid[k];
                    r_a[k]     <= w_up_a[k];
                    r_b[k]     <= w_up_b[k];
                    r_res[k]   <= w_up_res[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_txn_count <= '0;
        end else if (out_valid && out_ready) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    // Handshake outputs are masked so they read low for the whole reset window.
    assign in_ready  = w_load[0] & reset;
    assign out_valid = r_valid[DEPTH-1] & reset;
    assign A_out     = r_a[DEPTH-1];
    assign B_out     = r_b[DEPTH-1];
    assign LOGIC_out = r_res[DEPTH-1];
    assign txn_count = r_txn_count;

endmodule

`default_nettype wire

// File: tb/tb_swing_pipeline.sv
//============================================================================
// Module      : tb_swing_pipeline
// Description : Directed and randomized self-checking bench for swing_pipeline.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_swing_pipeline;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  a_in, b_in, c_in;
    logic [1:0]  mode;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid;
    logic [3:0]  a_out, b_out, logic_out;
    logic [15:0] txn_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    swing_pipeline #(.WIDTH(4), .DEPTH(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .A_in      (a_in),
        .B_in      (b_in),
        .C_in      (c_in),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_out     (a_out),
        .B_out     (b_out),
        .LOGIC_out (logic_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .txn_count (txn_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: count ones per bit position rather than using gate formulas.
    function automatic logic [3:0] ref_logic(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] c, input logic [1:0] m);
        logic [3:0] r;
        int ones;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
            case (m)
                2'd0:    r[i] = (ones == 3);
                2'd1:    r[i] = (ones >= 1);
                2'd2:    r[i] = (ones % 2 == 1);
                default: r[i] = (ones >= 2);
            endcase
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [1:0] m, input logic v);
        a_in = a; b_in = b; c_in = c; mode = m; in_valid = v;
    endtask

    // Randomized handshake runs against independent instances of several depths.
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int D = (gi == 0) ? 1 : (gi == 1) ? 2 : 5;
        logic        rrst, riv, ror, rir, rov;
        logic [3:0]  ra, rb, rc, rao, rbo, rlo;
        logic [1:0]  rm;
        logic [15:0] rtc;
        logic [11:0] q[$];
        logic [11:0] e;
        int          acc, hs, cyc;
        bit          done = 1'b0;

        swing_pipeline #(.WIDTH(4), .DEPTH(D)) u_rdut (
            .clk       (clk),
            .reset     (rrst),
            .A_in      (ra),
            .B_in      (rb),
            .C_in      (rc),
            .mode      (rm),
            .in_valid  (riv),
            .in_ready  (rir),
            .A_out     (rao),
            .B_out     (rbo),
            .LOGIC_out (rlo),
            .out_valid (rov),
            .out_ready (ror),
            .txn_count (rtc)
        );

        initial begin
            acc = 0; hs = 0; cyc = 0;
            rrst = 1'b0; riv = 1'b0; ror = 1'b0;
            ra = '0; rb = '0; rc = '0; rm = '0;
            repeat (2) @(posedge clk);
            #1;
            rrst = 1'b1;
            while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
                riv = (acc < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                ror = (acc < 1000) ? ($urandom_range(0, 2) != 0) : 1'b1;
                ra  = 4'($urandom);
                rb  = 4'($urandom);
                rc  = 4'($urandom);
                rm  = 2'($urandom);
                #1;
                if (riv && rir) begin
                    q.push_back({ra, rb, ref_logic(ra, rb, rc, rm)});
                    acc++;
                end
                if (rov && ror) begin
                    if (q.size() == 0) begin
                        check($sformatf("rand_d%0d_spurious", D), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("rand_d%0d_out", D), {20'd0, rao, rbo, rlo}, {20'd0, e});
                    end
                    hs++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            check($sformatf("rand_d%0d_accepted", D), acc, 1000);
            check($sformatf("rand_d%0d_queue_empty", D), q.size(), 0);
            check($sformatf("rand_d%0d_txn_count", D), {16'd0, rtc}, hs);
            done = 1'b1;
        end
    end

    typedef struct {
        logic [3:0] a, b, c;
        logic [1:0] m;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[4];

    initial begin
        int n;
        tbl[0] = '{4'b1011, 4'b0110, 4'b0101, 2'b00, 4'b0000};
        tbl[1] = '{4'b1011, 4'b0110, 4'b0101, 2'b01, 4'b1111};
        tbl[2] = '{4'b1011, 4'b0110, 4'b0101, 2'b10, 4'b1000};
        tbl[3] = '{4'b1011, 4'b0110, 4'b0101, 2'b11, 4'b0111};

        reset = 1'b0; out_ready = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        tick; tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_txn_count", txn_count, 0);
        check("rst_data", {a_out, b_out, logic_out}, 0);

        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Back-to-back table vectors, results two cycles after acceptance.
        for (int k = 0; k < 6; k++) begin
            if (k < 4) set_in(tbl[k].a, tbl[k].b, tbl[k].c, tbl[k].m, 1'b1);
            else       in_valid = 1'b0;
            out_ready = 1'b1;
            #1;
            if (k < 4) check($sformatf("vec%0d_in_ready", k), in_ready, 1);
            tick;
            if (k == 0 || k == 5) begin
                check($sformatf("vec_gap%0d_out_valid", k), out_valid, 0);
            end else begin
                check($sformatf("vec%0d_out_valid", k - 1), out_valid, 1);
                check($sformatf("vec%0d_logic", k - 1), logic_out, tbl[k-1].exp);
                check($sformatf("vec%0d_ab", k - 1), {a_out, b_out}, {tbl[k-1].a, tbl[k-1].b});
            end
        end
        check("vec_txn_count", txn_count, 4);

        // Stall: fill both stages, refuse a third set, then drain in order.
        out_ready = 1'b0;
        set_in(4'b1111, 4'b1101, 4'b1111, 2'b00, 1'b1);
        #1;
        check("stall_in_ready_1", in_ready, 1);
        tick;
        set_in(4'b0011, 4'b0101, 4'b0110, 2'b01, 1'b1);
        #1;
        check("stall_in_ready_2", in_ready, 1);
        tick;
        set_in(4'b1000, 4'b0001, 4'b0010, 2'b10, 1'b1);
        #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_in_ready", k), in_ready, 0);
            check($sformatf("stall%0d_out_valid", k), out_valid, 1);
            check($sformatf("stall%0d_out", k), {a_out, b_out, logic_out}, {4'b1111, 4'b1101, 4'b1101});
            tick;
        end
        out_ready = 1'b1;
        #1;
        check("full_accept_in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        check("drain1_out_valid", out_valid, 1);
        check("drain1_logic", logic_out, 4'b0111);
        tick;
        check("drain2_out_valid", out_valid, 1);
        check("drain2_logic", logic_out, 4'b1011);
        tick;
        check("drain_empty", out_valid, 0);
        check("drain_txn_count", txn_count, 7);

        // Reset with two results in flight.
        out_ready = 1'b0;
        set_in(4'b0001, 4'b0010, 4'b0100, 2'b01, 1'b1);
        tick;
        set_in(4'b1110, 4'b0010, 4'b0100, 2'b11, 1'b1);
        tick;
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("inrst_in_ready_pre", in_ready, 0);
        check("inrst_out_valid_pre", out_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick;
            check($sformatf("inrst%0d_in_ready", k), in_ready, 0);
            check($sformatf("inrst%0d_out_valid", k), out_valid, 0);
            check($sformatf("inrst%0d_txn", k), txn_count, 0);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        set_in(4'b0101, 4'b1010, 4'b1100, 2'b10, 1'b1);
        #1;
        tick;
        in_valid = 1'b0;
        check("after_rst_no_stale", out_valid, 0);
        tick;
        check("after_rst_out_valid", out_valid, 1);
        check("after_rst_logic", logic_out, 4'b0011);
        tick;
        check("after_rst_empty", out_valid, 0);
        check("after_rst_txn", txn_count, 1);

        // Stream until the counter reaches its maximum, then one more consume.
        set_in(4'b1010, 4'b0101, 4'b1111, 2'b11, 1'b1);
        out_ready = 1'b1;
        n = 0;
        while (txn_count != 16'hFFFF && n < 70000) begin
            tick;
            n++;
        end
        check("wrap_reached_max", txn_count, 16'hFFFF);
        check("wrap_out_valid", out_valid, 1);
        tick;
        check("wrap_to_zero", txn_count, 0);
        in_valid = 1'b0;

        check("rand_runs_done", {29'd0, g_rand[2].done, g_rand[1].done, g_rand[0].done}, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/swing_pipeline.md
SWING_PIPELINE -- requirements
Module: swing_pipeline

Interface
REQ-001 Parameter WIDTH, default 4, is the data width of every operand and result bus.
REQ-002 Parameter DEPTH, default 2, is the number of pipeline stages; legal range 1..8.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising clk edge.
REQ-005 A_in, B_in, C_in  input  WIDTH each  operands.
REQ-006 mode  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 bitwise majority.
REQ-007 in_valid  input  1  the upstream has an operand set on A_in/B_in/C_in/mode.
REQ-008 in_ready  output  1  the block accepts the operand set this cycle.
REQ-009 A_out, B_out  output  WIDTH each  registered copies of the accepted A_in and B_in.
REQ-010 LOGIC_out  output  WIDTH  the result of mode applied to the accepted A, B and C.
REQ-011 out_valid  output  1  A_out/B_out/LOGIC_out hold a valid result.
REQ-012 out_ready  input  1  the downstream consumes the result this cycle.
REQ-013 txn_count  output  16  count of results consumed since reset.

Function
REQ-014 An operand set is accepted on any rising edge where in_valid=1 and in_ready=1; all other input values are ignored.
REQ-015 The result is computed combinationally from the values sampled at acceptance:
- AND = A&B&C
- OR = A|B|C
- XOR = A^B^C
- majority = (A&B)|(A&C)|(B&C)
REQ-016 Each of the DEPTH stages holds one valid bit plus the A, B and result fields; the last stage drives A_out, B_out, LOGIC_out and out_valid.
REQ-017 Stage k loads from stage k-1 (stage 0 loads from the inputs) when stage k is empty or stage k+1 loads this cycle; the last stage loads when it is empty or out_ready=1.
REQ-018 When a stage loads, its valid bit takes the upstream valid; a stage that passes its content on without reloading becomes invalid.
REQ-019 in_ready is combinational: it equals the load condition of stage 0 and does not depend on in_valid.
REQ-020 With no stall, an operand set accepted at edge N shows out_valid=1 and its result after edge N+DEPTH-1, i.e. a latency of DEPTH cycles.
REQ-021 Throughput is one result per cycle while out_ready=1.
REQ-022 While out_valid=1 and out_ready=0:
- A_out, B_out and LOGIC_out hold stable;
- the pipeline fills, and in_ready falls once all DEPTH stages are valid;
- no operand set is dropped or duplicated.
REQ-023 Results leave in acceptance order.
REQ-024 txn_count increments by 1 on each edge where out_valid=1 and out_ready=1, and wraps from 16'hFFFF to 0.
REQ-025 Output data while out_valid=0 is don't-care, but it shall not be X after reset.
REQ-026 Accept and consume in the same cycle on a full pipeline is legal and keeps the occupancy unchanged.

Reset
REQ-027 On any rising edge with reset=0, the block shall clear every stage valid bit, all data registers and txn_count to 0, regardless of in-flight content; in-flight results are discarded.
REQ-028 While reset=0, in_ready shall read 0 and out_valid shall read 0; no acceptance occurs.
REQ-029 The first acceptance is possible on the first edge after reset returns to 1.

Verification
REQ-030 WIDTH=4, DEPTH=2. A=1011, B=0110, C=0101 are sent with mode 00, 01, 10, 11 on back-to-back cycles, out_ready=1 -> LOGIC_out reads 0000, 1111, 1000, 0111 on four consecutive cycles starting 2 cycles after the first accept; A_out=1011 and B_out=0110 each cycle; txn_count=4.
REQ-031 A=1111, B=1101, C=1111, mode=00, with out_ready=0 for 5 cycles -> out_valid=1 and LOGIC_out=1101 hold stable. After the pipeline holds 2 entries, in_ready=0 and a third offered set is not accepted. On out_ready=1, results drain in order.
REQ-032 Random in_valid/out_ready toggling, 1000 transactions, DEPTH=1,2,5 -> the output sequence exactly matches a reference queue and txn_count equals the number of handshakes.
REQ-033 reset=0 driven for 3 cycles with 2 results in flight -> out_valid=0, in_ready=0 and txn_count=0 throughout. After release, A=0101, B=1010, C=1100, mode=10 gives LOGIC_out=0011 with no stale outputs.
REQ-034 txn_count preloaded by 65535 consumes -> it wraps to 0 on the next consume.
